clip_edge_interp: RTL

Parametrised clip-edge intersection and attribute interpolation unit for the preprocessing (clipping) stage. It takes one polygon edge (two vertices with position and NUM_ATTR extra attributes) and one clip plane, all in signed fixed point. It computes the plane parameter t with an exact restoring divider, then linearly interpolates position and attributes, one component per cycle. Transfers use a valid/ready handshake in both directions, so the unit sits between the clip-edge walker and the output vertex FIFO.

---
 rtl/clip_edge_interp.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/clip_edge_interp.sv
// Clip-edge intersection: plane distances, exact t = d1/(d1-d2) by restoring
// division, then per-component linear interpolation of position and attributes.
//
// state | meaning
// IDLE  | ready for a new edge, captures inputs on handshake
// DIST  | accumulate plane.v1 and plane.v2, one component per cycle
// CHECK | form d1, d2, den; decide degenerate / clamp / divide
// DIV   | restoring divider, one quotient bit per cycle, MSB first
// LERP  | interpolate one component per cycle into output registers
// OUT   | result valid, held until consumer accepts
module clip_edge_interp #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 16,
   parameter int NUM_ATTR  = 4,
   localparam int AW       = ((NUM_ATTR > 0) ? NUM_ATTR : 1) * WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [4*WIDTH-1:0] v1_pos_i,
   input  logic [4*WIDTH-1:0] v2_pos_i,
   input  logic [AW-1:0]      v1_attr_i,
   input  logic [AW-1:0]      v2_attr_i,
   input  logic [4*WIDTH-1:0] plane_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [4*WIDTH-1:0] pos_o,
   output logic [AW-1:0]      attr_o,
   output logic [WIDTH-1:0]   t_o,
   output logic               degenerate_o,
   output logic               clamped_o
);
   localparam int NC   = 4 + NUM_ATTR;
   localparam int MAXC = (FRAC_BITS > NC) ? FRAC_BITS : NC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int ACCW = 2 * WIDTH + 2;
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
   localparam logic signed [ACCW-1:0] DMAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACCW-1:0] DMIN = ~DMAX;

   typedef enum logic [2:0] {IDLE, DIST, CHECK, DIV, LERP, OUT} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q;
   logic signed [WIDTH-1:0]  a_q [NC];
   logic signed [WIDTH-1:0]  b_q [NC];
   logic signed [WIDTH-1:0]  res_q [NC];
   logic signed [WIDTH-1:0]  plane_q [4];
   logic signed [ACCW-1:0]   acc1_q, acc2_q;
   logic [WIDTH-1:0]         t_q, t_out_q;
   logic [WIDTH:0]           rem_q, den_q;
   logic                     deg_q, clp_q;

   logic signed [WIDTH-1:0]  p_sel, x1_sel, x2_sel, a_sel, b_sel;
   logic signed [2*WIDTH-1:0] prod1, prod2;
   logic signed [WIDTH-1:0]  d1, d2;
   logic signed [WIDTH:0]    den, diff;
   logic signed [ACCW-1:0]   tprod;
   logic signed [WIDTH-1:0]  lerp_v;
   logic [WIDTH+1:0]         rem_sh, den_ext;
   logic                     ge, den_le0, d1_le0, d2_ge0, skip_div;

   // Distance is floor(acc / ONE), saturated into the signed WIDTH range.
   function automatic logic signed [WIDTH-1:0] sat_dist(input logic signed [ACCW-1:0] acc);
      logic signed [ACCW-1:0] s;
      s = acc >>> FRAC_BITS;
      if (s > DMAX)      return {1'b0, {(WIDTH-1){1'b1}}};
      else if (s < DMIN) return {1'b1, {(WIDTH-1){1'b0}}};
      else               return s[WIDTH-1:0];
   endfunction

   // Operand selection and datapath arithmetic for the current component.
   always_comb begin
      p_sel  = '0;
      x1_sel = '0;
      x2_sel = '0;
      a_sel  = '0;
      b_sel  = '0;
      for (int i = 0; i < 4; i++) begin
         if (cnt_q == CW'(i)) begin
            p_sel  = plane_q[i];
            x1_sel = a_q[i];
            x2_sel = b_q[i];
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (cnt_q == CW'(i)) begin
            a_sel = a_q[i];
            b_sel = b_q[i];
         end
      end
      prod1    = p_sel * x1_sel;
      prod2    = p_sel * x2_sel;
      d1       = sat_dist(acc1_q);
      d2       = sat_dist(acc2_q);
      den      = {d1[WIDTH-1], d1} - {d2[WIDTH-1], d2};
      den_le0  = den[WIDTH] || (den == '0);
      d1_le0   = d1[WIDTH-1] || (d1 == '0);
      d2_ge0   = !d2[WIDTH-1];
      skip_div = den_le0 || d1_le0 || d2_ge0;
      rem_sh   = {rem_q, 1'b0};
      den_ext  = {1'b0, den_q};
      ge       = (rem_sh >= den_ext);
      diff     = {b_sel[WIDTH-1], b_sel} - {a_sel[WIDTH-1], a_sel};
      tprod    = $signed({1'b0, t_q}) * diff;
      lerp_v   = a_sel + WIDTH'(tprod >>> FRAC_BITS);
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (in_valid_i) state_d = DIST;
         DIST:  if (cnt_q == CW'(3)) state_d = CHECK;
         CHECK: state_d = skip_div ? LERP : DIV;
         DIV:   if (cnt_q == CW'(FRAC_BITS - 1)) state_d = LERP;
         LERP:  if (cnt_q == CW'(NC - 1)) state_d = OUT;
         OUT:   if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc1_q  <= '0;
         acc2_q  <= '0;
         t_q     <= '0;
         t_out_q <= '0;
         rem_q   <= '0;
         den_q   <= '0;
         deg_q   <= 1'b0;
         clp_q   <= 1'b0;
         for (int i = 0; i < 4; i++) plane_q[i] <= '0;
         for (int i = 0; i < NC; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            res_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_d != state_q) cnt_q <= '0;
         else if (state_q == DIST || state_q == DIV || state_q == LERP) cnt_q <= cnt_q + 1'b1;
         case (state_q)
            IDLE: if (in_valid_i) begin
               acc1_q <= '0;
               acc2_q <= '0;
               for (int i = 0; i < 4; i++) begin
                  plane_q[i] <= plane_i[i*WIDTH +: WIDTH];
                  a_q[i]     <= v1_pos_i[i*WIDTH +: WIDTH];
                  b_q[i]     <= v2_pos_i[i*WIDTH +: WIDTH];
               end
               for (int i = 0; i < NUM_ATTR; i++) begin
                  a_q[4+i] <= v1_attr_i[i*WIDTH +: WIDTH];
                  b_q[4+i] <= v2_attr_i[i*WIDTH +: WIDTH];
               end
            end
            DIST: begin
               acc1_q <= acc1_q + {{2{prod1[2*WIDTH-1]}}, prod1};
               acc2_q <= acc2_q + {{2{prod2[2*WIDTH-1]}}, prod2};
            end
            CHECK: begin
               deg_q <= den_le0;
               clp_q <= !den_le0 && (d1_le0 || d2_ge0);
               t_q   <= (!den_le0 && !d1_le0 && d2_ge0) ? ONE : '0;
               rem_q <= {1'b0, d1};
               den_q <= den;
            end
            DIV: begin
               rem_q <= ge ? (WIDTH+1)'(rem_sh - den_ext) : {rem_q[WIDTH-1:0], 1'b0};
               t_q   <= {t_q[WIDTH-2:0], ge};
            end
            LERP: begin
               t_out_q <= t_q;
               for (int i = 0; i < NC; i++)
                  if (cnt_q == CW'(i)) res_q[i] <= lerp_v;
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o   = (state_q == IDLE);
   assign out_valid_o  = (state_q == OUT);
   assign t_o          = t_out_q;
   assign degenerate_o = deg_q;
   assign clamped_o    = clp_q;

   for (genvar k = 0; k < 4; k++) begin : g_pos
      assign pos_o[k*WIDTH +: WIDTH] = res_q[k];
   end
   if (NUM_ATTR > 0) begin : g_attr
      for (genvar k = 0; k < NUM_ATTR; k++) begin : g_a
         assign attr_o[k*WIDTH +: WIDTH] = res_q[4+k];
      end
   end else begin : g_noattr
      assign attr_o = '0;
   end
endmodule
